// File: rtl/psys_pkg.sv
// psys_pkg: shared widths and shadow-bank state encoding for the weight ping-pong buffer
package psys_pkg;
    localparam int DATA_W = 6144;
    localparam int SUB_W  = 1536;
    localparam int SUBS   = 4;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FILL  = 2'd1,
        READY = 2'd2
    } shadow_state_e;
endpackage

// File: rtl/psys_wbank.sv
// psys_wbank: one DEPTH x DATA_W simple-dual-port weight bank with registered read
// Ports: clk, rst_n (async, clears only the read register);
//        we/waddr/wdata write port; re/raddr read strobe/address; rdata registered read data (holds when re=0).
module psys_wbank #(
    parameter int DATA_W = 6144,
    parameter int DEPTH  = 16,
    parameter int AW     = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q, rdata_d;

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    always_comb rdata_d = re ? mem[raddr] : rdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdata_q <= '0;
        else        rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/psys_weight_pingpong.sv
// psys_weight_pingpong: two-bank weight buffer; loads the shadow bank while the array reads the active one
// Ports: clk, rst_n (async active-low);
//        s_axis_tdata/tvalid/tready beat stream, s_axis_tlast/weight_switch per-sub-beat tags (any tlast bit ends a group);
//        rd_en/rd_addr -> rd_data/rd_oob one-cycle read of the active bank;
//        array_release pulse frees the active bank;
//        active_valid/active_len/active_switch describe the active group; overflow_err is sticky.
module psys_weight_pingpong #(
    parameter int DATA_W = psys_pkg::DATA_W,
    parameter int DEPTH  = 16,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [DATA_W-1:0]       s_axis_tdata,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    input  logic [psys_pkg::SUBS-1:0] s_axis_tlast,
    input  logic [psys_pkg::SUBS-1:0] s_axis_weight_switch,
    input  logic                    rd_en,
    input  logic [AW-1:0]           rd_addr,
    output logic [DATA_W-1:0]       rd_data,
    output logic                    rd_oob,
    input  logic                    array_release,
    output logic                    active_valid,
    output logic [AW:0]             active_len,
    output logic                    active_switch,
    output logic                    overflow_err
);
    import psys_pkg::*;

    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

    shadow_state_e     state_q, state_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic              sw_acc_q, sw_acc_d;
    logic [AW:0]       shadow_len_q, shadow_len_d;
    logic              shadow_sw_q, shadow_sw_d;
    logic              bank_sel_q, bank_sel_d;
    logic              active_valid_q, active_valid_d;
    logic [AW:0]       active_len_q, active_len_d;
    logic              active_switch_q, active_switch_d;
    logic              overflow_q, overflow_d;
    logic              tready_q, tready_d;
    logic              rd_oob_q, rd_oob_d;
    logic              rd_bank_q, rd_bank_d;
    logic              accept, grp_end, swap;
    logic [DATA_W-1:0] rdata0, rdata1;

    always_comb begin
        accept          = s_axis_tvalid & tready_q;
        grp_end         = accept & ((|s_axis_tlast) | (wr_ptr_q == LAST_PTR));
        // swap looks only at registered state, so a group end never swaps in its own cycle
        swap            = (state_q == READY) & (~active_valid_q | array_release);
        state_d         = state_q;
        wr_ptr_d        = wr_ptr_q;
        sw_acc_d        = sw_acc_q;
        shadow_len_d    = shadow_len_q;
        shadow_sw_d     = shadow_sw_q;
        bank_sel_d      = bank_sel_q;
        active_valid_d  = active_valid_q;
        active_len_d    = active_len_q;
        active_switch_d = active_switch_q;
        overflow_d      = overflow_q | (accept & ~(|s_axis_tlast) & (wr_ptr_q == LAST_PTR));
        rd_oob_d        = rd_en ? (~active_valid_q | ({1'b0, rd_addr} >= active_len_q)) : rd_oob_q;
        rd_bank_d       = rd_en ? bank_sel_q : rd_bank_q;
        if (accept) begin
            state_d  = FILL;
            wr_ptr_d = wr_ptr_q + 1'b1;
            sw_acc_d = sw_acc_q | (|s_axis_weight_switch);
        end
        if (grp_end) begin
            state_d      = READY;
            shadow_len_d = {1'b0, wr_ptr_q} + 1'b1;
            shadow_sw_d  = sw_acc_q | (|s_axis_weight_switch);
            wr_ptr_d     = '0;
            sw_acc_d     = 1'b0;
        end
        if (swap) begin
            state_d         = EMPTY;
            bank_sel_d      = ~bank_sel_q;
            active_valid_d  = 1'b1;
            active_len_d    = shadow_len_q;
            active_switch_d = shadow_sw_q;
        end else if (array_release & active_valid_q) begin
            active_valid_d  = 1'b0;
            active_len_d    = '0;
            active_switch_d = 1'b0;
        end
        tready_d = (state_d != READY);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= EMPTY;
            wr_ptr_q        <= '0;
            sw_acc_q        <= 1'b0;
            shadow_len_q    <= '0;
            shadow_sw_q     <= 1'b0;
            bank_sel_q      <= 1'b0;
            active_valid_q  <= 1'b0;
            active_len_q    <= '0;
            active_switch_q <= 1'b0;
            overflow_q      <= 1'b0;
            tready_q        <= 1'b0;
            rd_oob_q        <= 1'b0;
            rd_bank_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            wr_ptr_q        <= wr_ptr_d;
            sw_acc_q        <= sw_acc_d;
            shadow_len_q    <= shadow_len_d;
            shadow_sw_q     <= shadow_sw_d;
            bank_sel_q      <= bank_sel_d;
            active_valid_q  <= active_valid_d;
            active_len_q    <= active_len_d;
            active_switch_q <= active_switch_d;
            overflow_q      <= overflow_d;
            tready_q        <= tready_d;
            rd_oob_q        <= rd_oob_d;
            rd_bank_q       <= rd_bank_d;
        end
    end

    // the shadow bank is the one bank_sel does not point at
    psys_wbank #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_bank0 (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (accept & bank_sel_q),
        .waddr (wr_ptr_q),
        .wdata (s_axis_tdata),
        .re    (rd_en & ~bank_sel_q),
        .raddr (rd_addr),
        .rdata (rdata0)
    );

    psys_wbank #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_bank1 (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (accept & ~bank_sel_q),
        .waddr (wr_ptr_q),
        .wdata (s_axis_tdata),
        .re    (rd_en & bank_sel_q),
        .raddr (rd_addr),
        .rdata (rdata1)
    );

    assign rd_data       = rd_bank_q ? rdata1 : rdata0;
    assign rd_oob        = rd_oob_q;
    assign s_axis_tready = tready_q;
    assign active_valid  = active_valid_q;
    assign active_len    = active_len_q;
    assign active_switch = active_switch_q;
    assign overflow_err  = overflow_q;
endmodule
